// File: rtl/sbox_arbiter.sv
// sbox_arbiter
// Shares one registered 4-byte AES S-box unit (S4) between two requesters.
// A round-robin FSM grants whole bursts, capped at MAX_BURST words. A
// one-stage tag pipeline routes each substituted word back to its issuer.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req0_valid/last/word/ready      port 0 burst handshake (32-bit words)
//   req1_valid/last/word/ready      port 1 burst handshake (32-bit words)
//   rsp0_valid, rsp1_valid          1-cycle pulse: rsp_word belongs to port N
//   rsp_word                        S4 output, 1 cycle after the transfer
//   busy                            a grant is active
//   owner                           current grant holder (1 = port 1)
module sbox_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_last,
    input  logic [31:0] req0_word,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_last,
    input  logic [31:0] req1_word,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_word,
    output logic        busy,
    output logic        owner
);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state, state_nxt;
    logic          prio, prio_nxt;
    logic [BW-1:0] beats, beats_nxt;
    logic          tag_v, tag_id;
    logic          xfer, cur_last, other_valid, release_now;
    logic [31:0]   cur_word;
    logic [31:0]   s4_in_p0;
    logic [31:0]   s4_p1;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES forward S-box: inverse as x^254 (maps 0 to 0), then the affine map
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Handshake decode: readies come from state alone
    always_comb begin
        req0_ready  = (state == GRANT0);
        req1_ready  = (state == GRANT1);
        busy        = (state != IDLE);
        owner       = (state == GRANT1);
        xfer        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        cur_last    = (state == GRANT1) ? req1_last : req0_last;
        cur_word    = (state == GRANT1) ? req1_word : req0_word;
        other_valid = (state == GRANT1) ? req0_valid : req1_valid;
        release_now = xfer && (cur_last || (beats == BW'(MAX_BURST - 1)));
        s4_in_p0    = xfer ? cur_word : 32'h0;
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        beats_nxt = beats;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) state_nxt = prio ? GRANT1 : GRANT0;
                else if (req0_valid)          state_nxt = GRANT0;
                else if (req1_valid)          state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (release_now) begin
                    beats_nxt = '0;
                    prio_nxt  = (state == GRANT0);
                    // Direct handover avoids the IDLE bubble when the other side waits
                    if (other_valid) state_nxt = (state == GRANT0) ? GRANT1 : GRANT0;
                    else             state_nxt = IDLE;
                end else if (xfer) begin
                    beats_nxt = beats + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            beats <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            beats <= beats_nxt;
        end
    end

    // Stage p0 -> p1: S4 register (data, no reset) and its routing tag
    always_ff @(posedge clk) begin
        s4_p1 <= {sbox_byte(s4_in_p0[31:24]), sbox_byte(s4_in_p0[23:16]),
                  sbox_byte(s4_in_p0[15:8]),  sbox_byte(s4_in_p0[7:0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v  <= 1'b0;
            tag_id <= 1'b0;
        end else begin
            tag_v  <= xfer;
            tag_id <= (state == GRANT1);
        end
    end

    assign rsp0_valid = tag_v && !tag_id;
    assign rsp1_valid = tag_v && tag_id;
    assign rsp_word   = s4_p1;
endmodule

// File: tb/tb_sbox_arbiter.sv
module tb_sbox_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_last, req0_ready;
    logic [31:0] req0_word;
    logic        req1_valid, req1_last, req1_ready;
    logic [31:0] req1_word;
    logic        rsp0_valid, rsp1_valid, busy, owner;
    logic [31:0] rsp_word;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    sbox_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_last(req0_last), .req0_word(req0_word), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_last(req1_last), .req1_word(req1_word), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_word(rsp_word),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sweep_word(input int idx);
        logic [7:0] b;
        b = 8'(idx * 4);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [31:0] sweep_exp(input int idx);
        logic [7:0] b;
        b = 8'(idx * 4);
        return {SBOX[b], SBOX[b + 8'd1], SBOX[b + 8'd2], SBOX[b + 8'd3]};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          budget;
        logic        xfer_now;
        logic [31:0] exp_w;

        rst = 1'b1;
        req0_valid = 1'b0; req0_last = 1'b0; req0_word = 32'h0;
        req1_valid = 1'b0; req1_last = 1'b0; req1_word = 32'h0;
        tick(); tick();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_word", rsp_word, 32'h63636363);

        // single word on port 0
        rst = 1'b0;
        req0_valid = 1'b1; req0_word = 32'h00010203; req0_last = 1'b1;
        chk("t1_ready_idle", req0_ready, 0);
        tick();
        chk("t1_ready", req0_ready, 1);
        chk("t1_busy", busy, 1);
        chk("t1_owner", owner, 0);
        chk("t1_rsp0_early", rsp0_valid, 0);
        tick();
        chk("t1_rsp0", rsp0_valid, 1);
        chk("t1_rsp1", rsp1_valid, 0);
        chk("t1_word", rsp_word, 32'h637c777b);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", req0_ready, 0);
        req0_valid = 1'b0; req0_last = 1'b0;
        tick();
        chk("t1_rsp0_off", rsp0_valid, 0);

        // forced release at MAX_BURST: port 1 streams 6 words, port 0 waits
        req1_valid = 1'b1; req1_word = 32'h00010203; req1_last = 1'b0;
        tick();
        chk("t3_ready1", req1_ready, 1);
        chk("t3_ready0", req0_ready, 0);
        chk("t3_owner", owner, 1);
        req0_valid = 1'b1; req0_word = 32'h01010101; req0_last = 1'b0;
        tick();
        chk("t3_w0_v", rsp1_valid, 1);
        chk("t3_w0", rsp_word, 32'h637c777b);
        req1_word = 32'h10111011;
        tick();
        chk("t3_w1", rsp_word, 32'hca82ca82);
        req1_word = 32'h20202020;
        tick();
        chk("t3_w2", rsp_word, 32'hb7b7b7b7);
        chk("t3_w2_ready1", req1_ready, 1);
        req1_word = 32'h53535353;
        tick();
        chk("t3_w3_v", rsp1_valid, 1);
        chk("t3_w3", rsp_word, 32'hedededed);
        chk("t3_hand_ready0", req0_ready, 1);
        chk("t3_hand_ready1", req1_ready, 0);
        chk("t3_hand_owner", owner, 0);
        req1_word = 32'h52525252;
        tick();
        chk("t3_a0_v0", rsp0_valid, 1);
        chk("t3_a0_v1", rsp1_valid, 0);
        chk("t3_a0", rsp_word, 32'h7c7c7c7c);
        req0_word = 32'h00000000; req0_last = 1'b1;
        tick();
        chk("t3_a1_v0", rsp0_valid, 1);
        chk("t3_a1", rsp_word, 32'h63636363);
        chk("t3_back_ready1", req1_ready, 1);
        chk("t3_back_ready0", req0_ready, 0);
        req0_valid = 1'b0; req0_last = 1'b0;
        tick();
        chk("t3_w4_v", rsp1_valid, 1);
        chk("t3_w4", rsp_word, 32'h00000000);
        req1_word = 32'hffffffff; req1_last = 1'b1;
        tick();
        chk("t3_w5_v", rsp1_valid, 1);
        chk("t3_w5", rsp_word, 32'h16161616);
        chk("t3_end_busy", busy, 0);
        req1_valid = 1'b0; req1_last = 1'b0;
        tick();
        chk("t3_end_rsp1", rsp1_valid, 0);

        // port 0 drops valid for 3 cycles mid-burst
        req0_valid = 1'b1; req0_word = 32'h01010101; req0_last = 1'b0;
        tick();
        chk("t4_ready", req0_ready, 1);
        tick();
        chk("t4_b1", rsp_word, 32'h7c7c7c7c);
        chk("t4_b1_v", rsp0_valid, 1);
        req0_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("t4_gap_ready", req0_ready, 1);
            tick();
            chk("t4_gap_rsp0", rsp0_valid, 0);
            chk("t4_gap_rsp1", rsp1_valid, 0);
        end
        req0_valid = 1'b1; req0_word = 32'h02020202;
        tick();
        chk("t4_b2", rsp_word, 32'h77777777);
        chk("t4_b2_ready", req0_ready, 1);
        req0_word = 32'h03030303;
        tick();
        chk("t4_b3", rsp_word, 32'h7b7b7b7b);
        chk("t4_b3_ready", req0_ready, 1);
        req0_word = 32'h11111111;
        tick();
        chk("t4_b4", rsp_word, 32'h82828282);
        chk("t4_b4_v", rsp0_valid, 1);
        chk("t4_forced_ready", req0_ready, 0);
        chk("t4_forced_busy", busy, 0);
        req0_valid = 1'b0;
        tick();
        chk("t4_end_rsp0", rsp0_valid, 0);

        // reset the cycle after a transfer
        req0_valid = 1'b1; req0_word = 32'h20202020; req0_last = 1'b0;
        tick();
        chk("t5_ready", req0_ready, 1);
        tick();
        chk("t5_rsp0_pre", rsp0_valid, 1);
        chk("t5_word_pre", rsp_word, 32'hb7b7b7b7);
        rst = 1'b1; req0_valid = 1'b0;
        #1;
        chk("t5_rsp0", rsp0_valid, 0);
        chk("t5_ready0", req0_ready, 0);
        chk("t5_ready1", req1_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_owner", owner, 0);
        tick();
        chk("t5_word", rsp_word, 32'h63636363);
        chk("t5_rsp0_after", rsp0_valid, 0);
        rst = 1'b0;

        // both valid from IDLE after reset: port 0 first, no bubble at handover
        req0_valid = 1'b1; req0_word = 32'h00000000; req0_last = 1'b0;
        req1_valid = 1'b1; req1_word = 32'h01010101; req1_last = 1'b0;
        tick();
        chk("t2_ready0", req0_ready, 1);
        chk("t2_ready1", req1_ready, 0);
        tick();
        chk("t2_r0_v", rsp0_valid, 1);
        chk("t2_r0", rsp_word, 32'h63636363);
        req0_word = 32'h53ff5200; req0_last = 1'b1;
        tick();
        chk("t2_r1_v", rsp0_valid, 1);
        chk("t2_r1", rsp_word, 32'hed160063);
        chk("t2_hand_ready1", req1_ready, 1);
        chk("t2_hand_owner", owner, 1);
        req0_valid = 1'b0; req0_last = 1'b0;
        tick();
        chk("t2_r2_v1", rsp1_valid, 1);
        chk("t2_r2_v0", rsp0_valid, 0);
        chk("t2_r2", rsp_word, 32'h7c7c7c7c);
        req1_word = 32'hffffffff; req1_last = 1'b1;
        tick();
        chk("t2_r3_v1", rsp1_valid, 1);
        chk("t2_r3", rsp_word, 32'h16161616);
        chk("t2_end_busy", busy, 0);
        req1_valid = 1'b0; req1_last = 1'b0;
        tick();

        // all 256 byte values through port 1
        idx = 0;
        budget = 0;
        req1_valid = 1'b1;
        req1_word = sweep_word(0);
        req1_last = 1'b0;
        while (idx < 64 && budget < 400) begin
            xfer_now = req1_valid && req1_ready;
            exp_w = sweep_exp(idx);
            tick();
            budget++;
            chk("sweep_rsp1_v", rsp1_valid, xfer_now);
            chk("sweep_rsp0_v", rsp0_valid, 0);
            if (xfer_now) begin
                chk("sweep_word", rsp_word, exp_w);
                idx++;
                req1_word = sweep_word(idx);
                req1_last = ((idx % 3) == 2);
            end
        end
        req1_valid = 1'b0;
        req1_last = 1'b0;
        chk("sweep_done", idx, 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
